// File: rtl/mem_bus_access_pkg.sv
// Shared definitions for the MEM-stage data-access controller and its lane generator.
package mem_bus_access_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/mem_bus_access_if.sv
// Data-bus req/ack channel between the MEM-stage controller and DM or the device bridge.
interface mem_bus_access_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/mem_bus_access_lane_gen.sv
// Byte-enable, store-lane replication and misalignment decode from addr[1:0] and size.
module mem_lane_gen
    import mem_bus_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    // Size 11 falls into the word branch.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (size)
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                misalign  = 1'b0;
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                misalign  = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_access.sv
// MEM-stage data-access controller: alignment check, req/ack bus handshake with timeout,
// raw read word and addr[1:0] registered for the WB-stage load extender.
module mem_bus_access
    import mem_bus_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      stall,
    output logic                      done,
    output logic [31:0]               rdata_wb,
    output logic [1:0]                alo_wb,
    output logic                      exc_adel,
    output logic                      exc_ades,
    output logic                      exc_bus,
    mem_bus_access_if.master          bus
);

    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

    state_e      state_r;
    logic [7:0]  cnt_r;
    logic [1:0]  alo_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_wdata_r;

    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s;
    logic        misalign_s;

    mem_lane_gen u_lane_gen (
        .addr_lo   (req_addr[1:0]),
        .size      (req_size),
        .wdata     (req_wdata),
        .be        (be_s),
        .wdata_rep (wdata_rep_s),
        .misalign  (misalign_s)
    );

    // Stall is combinational so the request cycle itself is held; forced low under reset.
    assign stall = ~reset & ((state_r == BUSY) | ((state_r == IDLE) & req_valid));

    assign bus.bus_req   = bus_req_r;
    assign bus.bus_we    = bus_we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_be    = bus_be_r;
    assign bus.bus_wdata = bus_wdata_r;

    // Access FSM with registered bus drive, result capture and one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            alo_r       <= 2'b00;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'd0;
            done        <= 1'b0;
            rdata_wb    <= 32'd0;
            alo_wb      <= 2'b00;
            exc_adel    <= 1'b0;
            exc_ades    <= 1'b0;
            exc_bus     <= 1'b0;
        end else begin
            done     <= 1'b0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            exc_bus  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid && misalign_s) begin
                        done     <= 1'b1;
                        exc_adel <= ~req_we;
                        exc_ades <= req_we;
                    end else if (req_valid) begin
                        state_r     <= BUSY;
                        cnt_r       <= 8'd0;
                        alo_r       <= req_addr[1:0];
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= req_we;
                        bus_addr_r  <= {req_addr[31:2], 2'b00};
                        bus_be_r    <= be_s;
                        bus_wdata_r <= wdata_rep_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // Ack is tested first so it wins over the final timeout cycle.
                    if (bus.bus_ack) begin
                        bus_req_r <= 1'b0;
                        alo_wb    <= alo_r;
                        if (!bus_we_r) begin
                            rdata_wb <= bus.bus_rdata;
                        end else begin
                            rdata_wb <= rdata_wb;
                        end
                        done    <= 1'b1;
                        state_r <= RESP;
                    end else if (cnt_r == TO_LAST_C) begin
                        bus_req_r <= 1'b0;
                        cnt_r     <= cnt_r + 8'd1;
                        exc_bus   <= 1'b1;
                        done      <= 1'b1;
                        state_r   <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_access.sv
// Scoreboard bench for mem_bus_access: expected results queued at request, checked at done.
module tb_mem_bus_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_wb;
    logic [1:0]  alo_wb;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;

    mem_bus_access_if bus ();

    mem_bus_access #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata_wb  (rdata_wb),
        .alo_wb    (alo_wb),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_bus   (exc_bus),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  alo;
        logic        adel;
        logic        ades;
        logic        berr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl_rdata = 32'd0;
    logic [1:0]  mdl_alo = 2'b00;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-lane view: the access covers nb bytes from an nb-aligned base.
    function automatic void lane_model(input logic [1:0] size, input logic [1:0] lo,
                                       input logic [31:0] wd, output logic [3:0] be,
                                       output logic [31:0] rep, output logic mis);
        int nb;
        int base;
        nb   = (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
        mis  = (int'(lo) % nb) != 0;
        base = (int'(lo) / nb) * nb;
        for (int i = 0; i < 4; i++) begin
            be[i]        = (i >= base) && (i < base + nb);
            rep[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
    endfunction

    task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rresp, input int ack_dly,
                          output int lat, output int stl, output int nreq);
        exp_t        e;
        exp_t        got_e;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        mis;
        logic        tmo;
        int          wait_n;
        logic        seen;
        lane_model(size, addr[1:0], wdata, ebe, ewd, mis);
        tmo = !mis && (ack_dly < 0 || ack_dly >= TO);
        if (!mis && !tmo) begin
            mdl_alo = addr[1:0];
            if (!we) mdl_rdata = rresp;
        end
        e.rdata = mdl_rdata;
        e.alo   = mdl_alo;
        e.adel  = mis & ~we;
        e.ades  = mis & we;
        e.berr  = tmo;
        sb_q.push_back(e);
        lat = 0; stl = 0; nreq = 0; wait_n = 0; seen = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        bus.bus_ack = 1'b0;
        #1;
        check("done_idle", 32'(done), 32'd0);
        for (int c = 0; c < 64 && !seen; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                req_valid   = 1'b0;
                bus.bus_ack = 1'b0;
                if (bus.bus_req) begin
                    nreq++;
                    check("bus_be", 32'(bus.bus_be), 32'(ebe));
                    check("bus_wdata", bus.bus_wdata, ewd);
                    check("bus_addr", bus.bus_addr, {addr[31:2], 2'b00});
                    check("bus_we", 32'(bus.bus_we), 32'(we));
                    cap_be = bus.bus_be; cap_wdata = bus.bus_wdata; cap_we = bus.bus_we;
                    if (ack_dly >= 0 && wait_n == ack_dly) begin
                        bus.bus_ack   = 1'b1;
                        bus.bus_rdata = rresp;
                    end else begin
                        bus.bus_rdata = 32'hBAD0_0000 | 32'(wait_n);
                    end
                    wait_n++;
                end
                #1;
            end
            lat++;
            if (stall) stl++;
            if (done) begin
                seen  = 1'b1;
                got_e = sb_q.pop_front();
                check("rdata_wb", rdata_wb, got_e.rdata);
                check("alo_wb", 32'(alo_wb), 32'(got_e.alo));
                check("exc_adel", 32'(exc_adel), 32'(got_e.adel));
                check("exc_ades", 32'(exc_ades), 32'(got_e.ades));
                check("exc_bus", 32'(exc_bus), 32'(got_e.berr));
                check("bus_req_resp", 32'(bus.bus_req), 32'd0);
            end
        end
        bus.bus_ack = 1'b0;
        if (!seen) begin
            check("done_seen", 32'(seen), 32'd1);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic check_all_zero(input string ph);
        check({ph, "_stall"}, 32'(stall), 32'd0);
        check({ph, "_done"}, 32'(done), 32'd0);
        check({ph, "_rdata_wb"}, rdata_wb, 32'd0);
        check({ph, "_alo_wb"}, 32'(alo_wb), 32'd0);
        check({ph, "_exc"}, 32'({exc_adel, exc_ades, exc_bus}), 32'd0);
        check({ph, "_bus_req"}, 32'(bus.bus_req), 32'd0);
        check({ph, "_bus_we"}, 32'(bus.bus_we), 32'd0);
        check({ph, "_bus_be"}, 32'(bus.bus_be), 32'd0);
        check({ph, "_bus_addr"}, bus.bus_addr, 32'd0);
        check({ph, "_bus_wdata"}, bus.bus_wdata, 32'd0);
    endtask

    initial begin
        int lat, stl, nreq;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_addr = 32'd0; req_wdata = 32'd0; bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;

        // Aligned word load, ack on first BUSY cycle
        access(1'b0, 2'b00, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 0, lat, stl, nreq);
        check("word_ld_latency", 32'(lat), 32'd3);
        check("word_ld_stall", 32'(stl), 32'd2);
        check("word_ld_nreq", 32'(nreq), 32'd1);
        check("word_ld_be", 32'(cap_be), 32'h0000_000F);

        // Byte store to lane 3
        access(1'b1, 2'b10, 32'h1000_0003, 32'h0000_00A5, 32'h1111_1111, 1, lat, stl, nreq);
        check("sb_be", 32'(cap_be), 32'h0000_0008);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        check("sb_we", 32'(cap_we), 32'd1);
        check("sb_rdata_kept", rdata_wb, 32'hDEAD_BEEF);

        // Misaligned half load, then aligned half store at offset 2
        access(1'b0, 2'b01, 32'h2000_0001, 32'd0, 32'd0, 0, lat, stl, nreq);
        check("lh_mis_latency", 32'(lat), 32'd2);
        check("lh_mis_nreq", 32'(nreq), 32'd0);
        access(1'b1, 2'b01, 32'h2000_0002, 32'h0000_BEEF, 32'd0, 0, lat, stl, nreq);
        check("sh_be", 32'(cap_be), 32'h0000_000C);
        check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);

        // Size 11 behaves as word: aligned load, then misaligned store
        access(1'b0, 2'b11, 32'h0000_0024, 32'd0, 32'hCAFE_F00D, 0, lat, stl, nreq);
        access(1'b1, 2'b11, 32'h0000_0026, 32'h1234_5678, 32'd0, 0, lat, stl, nreq);

        // Timeout with no ack, then stray acks in IDLE are ignored
        access(1'b0, 2'b00, 32'h0000_0040, 32'd0, 32'h5555_5555, -1, lat, stl, nreq);
        check("tmo_nreq", 32'(nreq), 32'(TO));
        check("tmo_latency", 32'(lat), 32'(TO + 2));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.bus_ack = 1'b1; bus.bus_rdata = 32'h7777_7777;
            #1;
            check("stray_ack_done", 32'(done), 32'd0);
            check("stray_ack_req", 32'(bus.bus_req), 32'd0);
            check("stray_ack_rdata", rdata_wb, mdl_rdata);
        end
        bus.bus_ack = 1'b0;

        // Ack on the last permitted cycle wins over timeout
        access(1'b0, 2'b10, 32'h0000_0052, 32'd0, 32'h0A0B_0C0D, TO - 1, lat, stl, nreq);
        check("lastack_nreq", 32'(nreq), 32'(TO));

        // Reset in the middle of BUSY
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h0000_0080;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_bus_req", 32'(bus.bus_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        mdl_rdata = 32'd0; mdl_alo = 2'b00;
        access(1'b0, 2'b00, 32'h0000_0084, 32'd0, 32'h1234_5678, 1, lat, stl, nreq);
        check("post_rst_latency", 32'(lat), 32'd4);

        // Back-to-back loads with ack delayed two cycles
        access(1'b0, 2'b00, 32'h0000_0100, 32'd0, 32'hAAAA_0001, 2, lat, stl, nreq);
        check("b2b0_latency", 32'(lat), 32'd5);
        access(1'b0, 2'b10, 32'h0000_0106, 32'd0, 32'hBBBB_0002, 2, lat, stl, nreq);
        check("b2b1_nreq", 32'(nreq), 32'd3);
        access(1'b0, 2'b01, 32'h0000_010A, 32'd0, 32'hCCCC_0003, 2, lat, stl, nreq);
        check("b2b2_stall", 32'(stl), 32'd4);

        // Random mix
        for (int i = 0; i < 10; i++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                   $urandom, $urandom, int'($urandom_range(0, TO - 1)), lat, stl, nreq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
